// File: rtl/mem_stage_wait_pkg.sv
// mem_pkg: shared types and constants for the wait-state data-memory stage
// Contents: FSM state enum, access op encoding, wait-cycle limit.
package mem_pkg;
    typedef enum logic {IDLE, BUSY} state_t;
    typedef enum logic {OP_LOAD, OP_STORE} op_t;
    localparam int WAIT_MAX = 15;
endpackage

// File: rtl/mem_stage_wait_bank.sv
// mem_bank: single-port synchronous RAM with byte-enable write and registered read
// Ports: clk_i clock; rst_ni sync active-low reset (read register only);
//        we_i/be_i byte-lane write; re_i load into read register;
//        clr_i zero the read register; addr_i word index; wdata_i store data;
//        rdata_o registered read data.
module mem_bank #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                we_i,
    input  logic                re_i,
    input  logic                clr_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] be_i,
    output logic [DATA_W-1:0]   rdata_o
);
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;
    always_ff @(posedge clk_i) begin
        if (we_i)
            for (int i = 0; i < DATA_W/8; i++)
                if (be_i[i]) mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
    end
    // The read register doubles as the stage's held load result, so it alone is reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) rdata_q <= '0;
        else if (clr_i) rdata_q <= '0;
        else if (re_i) rdata_q <= mem[addr_i];
    end
    assign rdata_o = rdata_q;
endmodule

// File: rtl/mem_stage_wait.sv
// mem_stage_wait: pipeline MEM stage with programmable wait states, byte stores and range check
// Ports: clock, reset_n (sync active-low); MemRead/MemWrite request (store wins);
//        Zero/Branch/BranchNe -> PCSrc branch decision; address/writeData/byteEn access
//        operands; outputDataRead last load result; readValid/addrFault completion
//        pulses; stall holds upstream while an access is in flight.
module mem_stage_wait
    import mem_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                MemRead,
    input  logic                MemWrite,
    input  logic                Zero,
    input  logic                Branch,
    input  logic                BranchNe,
    input  logic [DATA_W-1:0]   address,
    input  logic [DATA_W-1:0]   writeData,
    input  logic [DATA_W/8-1:0] byteEn,
    output logic                PCSrc,
    output logic [DATA_W-1:0]   outputDataRead,
    output logic                readValid,
    output logic                addrFault,
    output logic                stall
);
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > WAIT_MAX) ? 4'(WAIT_MAX) : 4'(WAIT_CYCLES);
    state_t              state_q;
    op_t                 op_q;
    logic [3:0]          cnt_q;
    logic [DATA_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] be_q;
    logic                valid_q;
    logic                fault_q;
    logic                done;
    logic                oor;
    logic                we;
    logic                re;
    logic                clr;
    assign done = (state_q == BUSY) && (cnt_q == 4'd0);
    assign oor  = |addr_q[DATA_W-1:ADDR_W];
    // Writes are gated by reset_n because the array itself is never reset.
    assign we   = reset_n && done && (op_q == OP_STORE) && !oor;
    assign re   = done && (op_q == OP_LOAD) && !oor;
    assign clr  = done && oor;
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            valid_q <= done;
            fault_q <= done && oor;
            case (state_q)
                IDLE: if (MemRead || MemWrite) begin
                    op_q    <= MemWrite ? OP_STORE : OP_LOAD;
                    addr_q  <= address;
                    wdata_q <= writeData;
                    be_q    <= byteEn;
                    cnt_q   <= WAIT_INIT;
                    state_q <= BUSY;
                end
                BUSY: if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
                      else state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
    mem_bank #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_bank (
        .clk_i  (clock),
        .rst_ni (reset_n),
        .we_i   (we),
        .re_i   (re),
        .clr_i  (clr),
        .addr_i (addr_q[ADDR_W-1:0]),
        .wdata_i(wdata_q),
        .be_i   (be_q),
        .rdata_o(outputDataRead)
    );
    assign PCSrc     = Branch & (Zero ^ BranchNe);
    assign readValid = valid_q;
    assign addrFault = fault_q;
    assign stall     = (state_q == BUSY);
endmodule

// File: tb/tb_mem_stage_wait.sv
// tb_mem_stage_wait: directed self-checking bench for mem_stage_wait (WAIT_CYCLES=2)
module tb_mem_stage_wait;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        MemRead, MemWrite, Zero, Branch, BranchNe;
    logic [15:0] address, writeData;
    logic [1:0]  byteEn;
    logic        PCSrc, readValid, addrFault, stall;
    logic [15:0] outputDataRead;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clock = ~clock;

    mem_stage_wait #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(2)) dut (
        .clock(clock), .reset_n(reset_n), .MemRead(MemRead), .MemWrite(MemWrite),
        .Zero(Zero), .Branch(Branch), .BranchNe(BranchNe), .address(address),
        .writeData(writeData), .byteEn(byteEn), .PCSrc(PCSrc),
        .outputDataRead(outputDataRead), .readValid(readValid),
        .addrFault(addrFault), .stall(stall)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issues one request and observes a bounded window of 20 cycles after acceptance.
    task automatic access(input logic wr, input logic rd, input logic [15:0] a,
                          input logic [15:0] d, input logic [1:0] be,
                          output int stalls, output int valids, output int faults,
                          output int fault_w_valid);
        MemWrite = wr; MemRead = rd; address = a; writeData = d; byteEn = be;
        tick();
        MemWrite = 1'b0; MemRead = 1'b0; address = 16'hFFFF; writeData = 16'h0; byteEn = 2'b00;
        stalls = 0; valids = 0; faults = 0; fault_w_valid = 0;
        for (int k = 0; k < 20; k++) begin
            if (stall) stalls++;
            if (readValid) valids++;
            if (addrFault) faults++;
            if (addrFault && readValid) fault_w_valid++;
            tick();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Zero = 1'b0; Branch = 1'b0;
        BranchNe = 1'b0; address = 16'h0; writeData = 16'h0; byteEn = 2'b00;
        tick(); tick();
        n_checks++; if (outputDataRead !== 16'h0) begin n_fail++; $display("FAIL reset_data got=%h exp=0000", outputDataRead); end
        n_checks++; if (readValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", readValid); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", stall); end
        n_checks++; if (addrFault !== 1'b0) begin n_fail++; $display("FAIL reset_fault got=%b exp=0", addrFault); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_store_load();
        int s, v, f, fv;
        access(1'b1, 1'b0, 16'h0003, 16'hBEEF, 2'b11, s, v, f, fv);
        n_checks++; if (s != 3) begin n_fail++; $display("FAIL store_stall_cycles got=%0d exp=3", s); end
        n_checks++; if (v != 1) begin n_fail++; $display("FAIL store_valid_pulses got=%0d exp=1", v); end
        n_checks++; if (f != 0) begin n_fail++; $display("FAIL store_fault got=%0d exp=0", f); end
        n_checks++; if (outputDataRead !== 16'h0000) begin n_fail++; $display("FAIL store_keeps_data got=%h exp=0000", outputDataRead); end
        access(1'b0, 1'b1, 16'h0003, 16'h0, 2'b00, s, v, f, fv);
        n_checks++; if (s != 3) begin n_fail++; $display("FAIL load_stall_cycles got=%0d exp=3", s); end
        n_checks++; if (v != 1) begin n_fail++; $display("FAIL load_valid_pulses got=%0d exp=1", v); end
        n_checks++; if (outputDataRead !== 16'hBEEF) begin n_fail++; $display("FAIL load_data got=%h exp=beef", outputDataRead); end
    endtask

    task automatic test_byte_store();
        int s, v, f, fv;
        access(1'b1, 1'b0, 16'h0003, 16'h1234, 2'b01, s, v, f, fv);
        access(1'b0, 1'b1, 16'h0003, 16'h0, 2'b00, s, v, f, fv);
        n_checks++; if (outputDataRead !== 16'hBE34) begin n_fail++; $display("FAIL byte_low_store got=%h exp=be34", outputDataRead); end
        access(1'b1, 1'b0, 16'h0003, 16'hFFFF, 2'b00, s, v, f, fv);
        n_checks++; if (v != 1) begin n_fail++; $display("FAIL be00_valid got=%0d exp=1", v); end
        access(1'b0, 1'b1, 16'h0003, 16'h0, 2'b00, s, v, f, fv);
        n_checks++; if (outputDataRead !== 16'hBE34) begin n_fail++; $display("FAIL be00_no_change got=%h exp=be34", outputDataRead); end
        access(1'b1, 1'b0, 16'h0004, 16'hABCD, 2'b10, s, v, f, fv);
        access(1'b1, 1'b0, 16'h0004, 16'h0077, 2'b01, s, v, f, fv);
        access(1'b0, 1'b1, 16'h0004, 16'h0, 2'b00, s, v, f, fv);
        n_checks++; if (outputDataRead !== 16'hAB77) begin n_fail++; $display("FAIL byte_merge got=%h exp=ab77", outputDataRead); end
    endtask

    task automatic test_fault();
        int s, v, f, fv;
        access(1'b0, 1'b1, 16'h0103, 16'h0, 2'b00, s, v, f, fv);
        n_checks++; if (v != 1) begin n_fail++; $display("FAIL fault_valid got=%0d exp=1", v); end
        n_checks++; if (f != 1 || fv != 1) begin n_fail++; $display("FAIL fault_pulse got=%0d/%0d exp=1/1", f, fv); end
        n_checks++; if (outputDataRead !== 16'h0) begin n_fail++; $display("FAIL fault_data got=%h exp=0000", outputDataRead); end
        access(1'b1, 1'b0, 16'h8003, 16'h0000, 2'b11, s, v, f, fv);
        n_checks++; if (fv != 1) begin n_fail++; $display("FAIL fault_store_pulse got=%0d exp=1", fv); end
        access(1'b0, 1'b1, 16'h0003, 16'h0, 2'b00, s, v, f, fv);
        n_checks++; if (outputDataRead !== 16'hBE34) begin n_fail++; $display("FAIL fault_mem_intact got=%h exp=be34", outputDataRead); end
        n_checks++; if (f != 0) begin n_fail++; $display("FAIL inrange_no_fault got=%0d exp=0", f); end
    endtask

    task automatic test_both_high();
        int s, v, f, fv;
        access(1'b1, 1'b1, 16'h0005, 16'hA5A5, 2'b11, s, v, f, fv);
        n_checks++; if (outputDataRead !== 16'hBE34) begin n_fail++; $display("FAIL both_is_store got=%h exp=be34", outputDataRead); end
        access(1'b0, 1'b1, 16'h0005, 16'h0, 2'b00, s, v, f, fv);
        n_checks++; if (outputDataRead !== 16'hA5A5) begin n_fail++; $display("FAIL both_stored got=%h exp=a5a5", outputDataRead); end
    endtask

    task automatic test_branch();
        Branch = 1'b1; Zero = 1'b1; BranchNe = 1'b0; #1;
        n_checks++; if (PCSrc !== 1'b1) begin n_fail++; $display("FAIL beq_taken got=%b exp=1", PCSrc); end
        BranchNe = 1'b1; #1;
        n_checks++; if (PCSrc !== 1'b0) begin n_fail++; $display("FAIL bne_zero got=%b exp=0", PCSrc); end
        Zero = 1'b0; #1;
        n_checks++; if (PCSrc !== 1'b1) begin n_fail++; $display("FAIL bne_taken got=%b exp=1", PCSrc); end
        Branch = 1'b0; #1;
        n_checks++; if (PCSrc !== 1'b0) begin n_fail++; $display("FAIL nobranch got=%b exp=0", PCSrc); end
        MemRead = 1'b1; address = 16'h0003;
        tick();
        MemRead = 1'b0;
        Branch = 1'b1; Zero = 1'b0; BranchNe = 1'b1; #1;
        n_checks++; if (stall !== 1'b1 || PCSrc !== 1'b1) begin n_fail++; $display("FAIL branch_in_stall got=%b/%b exp=1/1", stall, PCSrc); end
        Branch = 1'b0; #1;
        n_checks++; if (PCSrc !== 1'b0) begin n_fail++; $display("FAIL nobranch_in_stall got=%b exp=0", PCSrc); end
        for (int k = 0; k < 6; k++) tick();
    endtask

    task automatic test_back_to_back();
        int guard;
        MemRead = 1'b1; address = 16'h0005;
        tick();
        MemRead = 1'b0;
        tick(); tick(); tick();
        n_checks++; if (readValid !== 1'b1 || stall !== 1'b0) begin n_fail++; $display("FAIL b2b_first_done got=%b/%b exp=1/0", readValid, stall); end
        n_checks++; if (outputDataRead !== 16'hA5A5) begin n_fail++; $display("FAIL b2b_first_data got=%h exp=a5a5", outputDataRead); end
        MemRead = 1'b1; address = 16'h0004;
        tick();
        MemRead = 1'b0;
        n_checks++; if (stall !== 1'b1 || readValid !== 1'b0) begin n_fail++; $display("FAIL b2b_accept got=%b/%b exp=1/0", stall, readValid); end
        guard = 0;
        while (!readValid && guard < 20) begin tick(); guard++; end
        n_checks++; if (guard != 3) begin n_fail++; $display("FAIL b2b_latency got=%0d exp=3", guard); end
        n_checks++; if (outputDataRead !== 16'hAB77) begin n_fail++; $display("FAIL b2b_second_data got=%h exp=ab77", outputDataRead); end
        tick();
    endtask

    task automatic test_reset_mid_busy();
        int s, v, f, fv;
        access(1'b1, 1'b0, 16'h0007, 16'h1111, 2'b11, s, v, f, fv);
        MemWrite = 1'b1; address = 16'h0007; writeData = 16'h5555; byteEn = 2'b11;
        tick();
        MemWrite = 1'b0;
        tick();
        reset_n = 1'b0;
        tick();
        n_checks++; if (stall !== 1'b0 || readValid !== 1'b0) begin n_fail++; $display("FAIL midbusy_reset got=%b/%b exp=0/0", stall, readValid); end
        n_checks++; if (outputDataRead !== 16'h0) begin n_fail++; $display("FAIL midbusy_data got=%h exp=0000", outputDataRead); end
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        n_checks++; if (readValid !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL midbusy_discard got=%b/%b exp=0/0", readValid, stall); end
        access(1'b0, 1'b1, 16'h0007, 16'h0, 2'b00, s, v, f, fv);
        n_checks++; if (outputDataRead !== 16'h1111) begin n_fail++; $display("FAIL midbusy_not_committed got=%h exp=1111", outputDataRead); end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_byte_store();
        test_fault();
        test_both_high();
        test_branch();
        test_back_to_back();
        test_reset_mid_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_stage_wait.md
# mem_stage_wait

Parametrised data-memory stage for the 16-bit processor pipeline, successor to the single-cycle MEM stage. Keeps branch resolution (PCSrc) and load/store access, and adds configurable data width and depth, byte-enabled stores, a programmable multi-cycle access latency with a stall output to freeze upstream stages, and out-of-range address detection. Sits between the execute stage (ALU result as address, second register operand as store data) and write-back.

## Interface

Parameters:
- DATA_W, 16: data and address bus width; multiple of 8.
- ADDR_W, 8: memory index width; depth = 2^ADDR_W words; ADDR_W < DATA_W.
- WAIT_CYCLES, 2: extra wait cycles per access, 0..15.

Ports:
- clock  in  1  single clock, all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- MemRead  in  1  load request.
- MemWrite  in  1  store request; wins over MemRead if both high.
- Zero  in  1  ALU zero flag.
- Branch  in  1  branch instruction.
- BranchNe  in  1  1 = branch-if-not-equal, 0 = branch-if-equal.
- address  in  DATA_W  word address (ALU result).
- writeData  in  DATA_W  store data.
- byteEn  in  DATA_W/8  store byte lanes; bit i covers bits 8i+7..8i.
- PCSrc  out  1  branch taken.
- outputDataRead  out  DATA_W  last completed load data.
- readValid  out  1  one-cycle pulse: access completed.
- addrFault  out  1  one-cycle pulse with readValid: completed access was out of range.
- stall  out  1  access in progress; upstream must hold.

## Operation

- PCSrc = Branch & (Zero ^ BranchNe); combinational, independent of FSM and stall.
- FSM states IDLE, BUSY; counter cnt (4 bits).
- IDLE: if MemRead|MemWrite at an edge -> capture op (write if MemWrite), address, writeData, byteEn; cnt <= WAIT_CYCLES; go BUSY. Otherwise stay IDLE.
- BUSY: stall = 1. Inputs MemRead/MemWrite/address/data ignored. If cnt != 0: cnt <= cnt-1. If cnt == 0: perform access at this edge, readValid <= 1, go IDLE.
- Range check: captured address bits DATA_W-1..ADDR_W nonzero -> fault: memory unchanged, addrFault <= 1 with readValid, outputDataRead <= 0 (for loads and stores).
- Load in range: outputDataRead <= mem[address[ADDR_W-1:0]].
- Store in range: for each i with byteEn[i]=1, byte i of word <= writeData byte i; byteEn all zero -> no change. outputDataRead unchanged on stores.
- outputDataRead holds its value until the next load or faulted access completes.
- Memory array is not reset; contents undefined until written.

## Timing

- Request accepted at edge E0 (state IDLE). stall = 1 from cycle after E0 through cycle before completion edge; completion at edge E0 + WAIT_CYCLES + 1.
- readValid/addrFault high for exactly the cycle after completion edge; stall low in that cycle; a new request may be accepted at the next edge (back-to-back throughput one access per WAIT_CYCLES+2 cycles).
- WAIT_CYCLES = 0: stall high for one cycle, data after two edges.
- Reset (reset_n = 0 at an edge): state IDLE, cnt 0, outputDataRead 0, readValid 0, addrFault 0, stall 0; pending access discarded (store not committed, even mid-BUSY). Has priority over all other activity.
- Both MemRead and MemWrite high at acceptance: treated as store.

## Structure

- Package mem_pkg: state enum (IDLE, BUSY), WAIT_CYCLES range constant (max 15), op encoding (OP_LOAD, OP_STORE).
- Sub-module mem_bank: single-port synchronous RAM, DATA_W x 2^ADDR_W, byte-enable write, registered read; top contains FSM, capture registers, range check, branch logic.

## Test plan

- Reset: hold reset_n=0 two edges -> outputDataRead 0, readValid 0, stall 0, addrFault 0.
- WAIT_CYCLES=2: store 0xBEEF to address 3 with byteEn 11, then load address 3 -> stall high 3 cycles per access, readValid one pulse each, outputDataRead 0xBEEF after load.
- Byte store: after above, store 0x1234 to address 3 with byteEn 01 -> load returns 0xBE34; byteEn 00 store -> still 0xBE34.
- Fault: load address 0x0103 (ADDR_W=8) -> readValid and addrFault pulse together, outputDataRead 0, memory at 0x03 unchanged.
- Branch: Branch=1, Zero=1, BranchNe=0 -> PCSrc 1; BranchNe=1 -> 0; Branch=0 -> 0, including while stall high.
- Reset mid-BUSY: store 0x5555 to address 7, assert reset_n=0 on second BUSY cycle -> stall drops, later load of address 7 returns prior value, not 0x5555.
